// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: FSM state encodings and response codes.
package axi4_lite_pkg;

    typedef enum logic {WrIdle, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdData} rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_wstrb_merge.sv
// Byte-enable merge: each strobed byte takes new write data, the rest keep the old value.
module axi4_lite_wstrb_merge #(
    parameter int unsigned DataWidth = 32
) (
    input  logic [DataWidth-1:0]   old_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    output logic [DataWidth-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < DataWidth / 8; b++) begin
            if (wstrb_i[b]) begin
                merged_o[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank with independent AW/W capture and concurrent read/write FSMs.
// Define AXI4_LITE_REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_regbank
    import axi4_lite_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR         = 32'h40000000,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_REGS         = 16,
    parameter logic [63:0] C_RESET_VALUE      = 64'h0
) (
    input  logic                                       S_AXI_ACLK,
    input  logic                                       S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
    input  logic                                       S_AXI_AWVALID,
    output logic                                       S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
    input  logic                                       S_AXI_WVALID,
    output logic                                       S_AXI_WREADY,
    output logic [1:0]                                 S_AXI_BRESP,
    output logic                                       S_AXI_BVALID,
    input  logic                                       S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
    input  logic                                       S_AXI_ARVALID,
    output logic                                       S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
    output logic [1:0]                                 S_AXI_RRESP,
    output logic                                       S_AXI_RVALID,
    input  logic                                       S_AXI_RREADY,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    output logic [C_NUM_REGS-1:0]                      reg_wr_stb,
    output logic [C_NUM_REGS-1:0]                      reg_rd_stb
);

    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW       = DW / 8;
    localparam int unsigned ADDR_LSB = $clog2(SW);
    localparam int unsigned IDX_W    = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

    localparam logic [AW-1:0] BASE    = AW'(C_BASEADDR);
    localparam logic [AW-1:0] NREGS   = AW'(C_NUM_REGS);
    localparam logic [DW-1:0] RST_VAL = DW'(C_RESET_VALUE);
`ifdef AXI4_LITE_REGBANK_SLVERR_EN
    localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

    // Addresses below the base wrap to huge indices and so fall out of range.
    function automatic logic [AW-1:0] addr_to_idx(input logic [AW-1:0] addr);
        return (addr - BASE) >> ADDR_LSB;
    endfunction

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic              aw_held_q, w_held_q;
    logic [AW-1:0]     aw_addr_q;
    logic [DW-1:0]     w_data_q;
    logic [SW-1:0]     w_strb_q;
    logic [DW-1:0]     regs_q [C_NUM_REGS];
    logic [1:0]        bresp_q, rresp_q;
    logic [DW-1:0]     rdata_q;
    logic [C_NUM_REGS-1:0] wr_stb_q, rd_stb_q;

    logic              aw_hs, w_hs, ar_hs, wr_commit;
    logic [AW-1:0]     wr_addr, wr_idx_full, rd_idx_full;
    logic [DW-1:0]     wr_data, merged;
    logic [SW-1:0]     wr_strb;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_in_range, rd_in_range;

    assign S_AXI_AWREADY = !S_AXI_ARESET && (wr_state_q == WrIdle) && !aw_held_q;
    assign S_AXI_WREADY  = !S_AXI_ARESET && (wr_state_q == WrIdle) && !w_held_q;
    assign S_AXI_ARREADY = !S_AXI_ARESET && (rd_state_q == RdIdle);
    assign S_AXI_BVALID  = (wr_state_q == WrResp);
    assign S_AXI_RVALID  = (rd_state_q == RdData);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_wr_stb    = wr_stb_q;
    assign reg_rd_stb    = rd_stb_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Commit on the later handshake edge, taking the live channel for whichever is not yet held.
    assign wr_addr   = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data   = w_held_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb   = w_held_q ? w_strb_q : S_AXI_WSTRB;
    assign wr_commit = (wr_state_q == WrIdle) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_idx_full = addr_to_idx(wr_addr);
    assign wr_in_range = wr_idx_full < NREGS;
    assign wr_idx      = wr_idx_full[IDX_W-1:0];
    assign rd_idx_full = addr_to_idx(S_AXI_ARADDR);
    assign rd_in_range = rd_idx_full < NREGS;
    assign rd_idx      = rd_idx_full[IDX_W-1:0];

    axi4_lite_wstrb_merge #(
        .DataWidth (DW)
    ) u_wstrb_merge (
        .old_i    (regs_q[wr_idx]),
        .wdata_i  (wr_data),
        .wstrb_i  (wr_strb),
        .merged_o (merged)
    );

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DW +: DW] = regs_q[i];
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WrIdle:  if (wr_commit) wr_state_d = WrResp;
            WrResp:  if (S_AXI_BREADY) wr_state_d = WrIdle;
            default: wr_state_d = WrIdle;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RdIdle:  if (ar_hs) rd_state_d = RdData;
            RdData:  if (S_AXI_RREADY) rd_state_d = RdIdle;
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= WrIdle;
            rd_state_q <= RdIdle;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            wr_stb_q   <= '0;
            rd_stb_q   <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_stb_q   <= '0;
            rd_stb_q   <= '0;

            if (wr_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bresp_q   <= wr_in_range ? RESP_OKAY : RESP_OOR;
                if (wr_in_range) begin
                    regs_q[wr_idx]   <= merged;
                    wr_stb_q[wr_idx] <= 1'b1;
                end
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end

            // Reads sample regs_q before this edge's write lands, so a colliding read sees old data.
            if (ar_hs) begin
                rdata_q <= rd_in_range ? regs_q[rd_idx] : '0;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_OOR;
                if (rd_in_range) begin
                    rd_stb_q[rd_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Directed bench for axi4_lite_regbank (default parameters, 16 x 32-bit registers).
module tb_axi4_lite_regbank;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef AXI4_LITE_REGBANK_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic         clk = 1'b0;
    logic         areset;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [511:0] reg_out;
    logic [15:0]  wr_stb, rd_stb;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    axi4_lite_regbank dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_wr_stb    (wr_stb),
        .reg_rd_stb    (rd_stb)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] reg_val(input int i);
        return 64'(reg_out[i*32 +: 32]);
    endfunction

    task automatic complete_b();
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_eq("b_done", 64'(bvalid), 64'h0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic [15:0] stb);
        araddr  = addr;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("rd_rvalid", 64'(rvalid), 64'h1);
        data = rdata;
        resp = rresp;
        stb  = rd_stb;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic [15:0] rd_s;

    initial begin
        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_awready", 64'(awready), 64'h0);
        check_eq("rst_wready", 64'(wready), 64'h0);
        check_eq("rst_arready", 64'(arready), 64'h0);
        check_eq("rst_bvalid", 64'(bvalid), 64'h0);
        check_eq("rst_rvalid", 64'(rvalid), 64'h0);
        check_eq("rst_strobes", 64'({wr_stb, rd_stb}), 64'h0);
        check_eq("rst_rdata", 64'(rdata), 64'h0);
        areset = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'({awready, wready, arready}), 64'h7);
        check_eq("post_rst_regs_zero", 64'(reg_out == '0), 64'h1);
        @(negedge clk);

        // AW and W together to reg 3
        awaddr = BASE + 32'd12; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("same_cyc_bvalid", 64'(bvalid), 64'h1);
        check_eq("same_cyc_bresp", 64'(bresp), 64'h0);
        check_eq("same_cyc_reg3", reg_val(3), 64'hDEADBEEF);
        check_eq("same_cyc_wr_stb", 64'(wr_stb), 64'h0008);
        check_eq("same_cyc_ready_low", 64'({awready, wready}), 64'h0);

        // Stall B for 5 cycles while a second write to reg 7 waits
        awaddr = BASE + 32'd28; awvalid = 1'b1;
        wdata = 32'h0000_0077; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_bvalid", 64'(bvalid), 64'h1);
            check_eq("stall_ready_low", 64'({awready, wready}), 64'h0);
            check_eq("stall_wr_stb", 64'(wr_stb), 64'h0);
        end
        check_eq("stall_reg7", reg_val(7), 64'h0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_eq("after_b_bvalid", 64'(bvalid), 64'h0);
        check_eq("after_b_awready", 64'(awready), 64'h1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("second_wr_bvalid", 64'(bvalid), 64'h1);
        check_eq("second_wr_reg7", reg_val(7), 64'h77);
        check_eq("second_wr_stb", 64'(wr_stb), 64'h0080);
        complete_b();

        // W three cycles ahead of AW, partial strobe to reg 5
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("w_held_wready", 64'(wready), 64'h0);
            check_eq("w_held_awready", 64'(awready), 64'h1);
            check_eq("w_held_bvalid", 64'(bvalid), 64'h0);
            if (i < 2) @(negedge clk);
        end
        awaddr = BASE + 32'd20; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check_eq("w_first_bvalid", 64'(bvalid), 64'h1);
        check_eq("w_first_reg5", reg_val(5), 64'h00220044);
        check_eq("w_first_stb", 64'(wr_stb), 64'h0020);
        complete_b();

        // Zero strobe: no data change, strobe and OKAY still
        awaddr = BASE + 32'd12; awvalid = 1'b1;
        wdata = 32'hFFFFFFFF; wstrb = 4'h0; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("strb0_reg3", reg_val(3), 64'hDEADBEEF);
        check_eq("strb0_stb", 64'(wr_stb), 64'h0008);
        check_eq("strb0_bresp", 64'(bresp), 64'h0);
        complete_b();

        // Read and write of reg 3 committing on the same edge
        awaddr = BASE + 32'd12; awvalid = 1'b1;
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        araddr = BASE + 32'd12; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("collide_rvalid", 64'(rvalid), 64'h1);
        check_eq("collide_rdata_old", 64'(rdata), 64'hDEADBEEF);
        check_eq("collide_rd_stb", 64'(rd_stb), 64'h0008);
        check_eq("collide_reg3_new", reg_val(3), 64'h1);
        check_eq("collide_bvalid", 64'(bvalid), 64'h1);
        @(negedge clk);
        check_eq("r_hold_rdata", 64'(rdata), 64'hDEADBEEF);
        check_eq("r_hold_rvalid", 64'(rvalid), 64'h1);
        check_eq("r_hold_rd_stb", 64'(rd_stb), 64'h0);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        check_eq("collide_done", 64'({rvalid, bvalid}), 64'h0);
        do_read(BASE + 32'd12, rd_data, rd_resp, rd_s);
        check_eq("reread_reg3", 64'(rd_data), 64'h1);
        check_eq("reread_resp", 64'(rd_resp), 64'h0);
        check_eq("reread_stb", 64'(rd_s), 64'h0008);

        // Out-of-range read and write
        do_read(BASE + 32'h40, rd_data, rd_resp, rd_s);
        check_eq("oor_rd_data", 64'(rd_data), 64'h0);
        check_eq("oor_rd_resp", 64'(rd_resp), 64'(OOR_RESP));
        check_eq("oor_rd_stb", 64'(rd_s), 64'h0);
        awaddr = BASE + 32'h80; awvalid = 1'b1;
        wdata = 32'hAAAA5555; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("oor_wr_bvalid", 64'(bvalid), 64'h1);
        check_eq("oor_wr_bresp", 64'(bresp), 64'(OOR_RESP));
        check_eq("oor_wr_stb", 64'(wr_stb), 64'h0);
        check_eq("oor_wr_reg0", reg_val(0), 64'h0);
        check_eq("oor_wr_reg3", reg_val(3), 64'h1);
        check_eq("oor_wr_reg5", reg_val(5), 64'h00220044);
        complete_b();

        // Reset while RVALID waits on RREADY
        araddr = BASE + 32'd20; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("pre_rst_rdata", 64'(rdata), 64'h00220044);
        @(negedge clk);
        check_eq("pre_rst_rvalid", 64'(rvalid), 64'h1);
        areset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_rvalid", 64'(rvalid), 64'h0);
        check_eq("mid_rst_arready", 64'(arready), 64'h0);
        check_eq("mid_rst_rdata", 64'(rdata), 64'h0);
        check_eq("mid_rst_regs_zero", 64'(reg_out == '0), 64'h1);
        areset = 1'b0;
        #1;
        check_eq("rel_rst_arready", 64'(arready), 64'h1);
        @(negedge clk);
        do_read(BASE + 32'd12, rd_data, rd_resp, rd_s);
        check_eq("post_rst_reg3", 64'(rd_data), 64'h0);
        do_read(BASE + 32'd20, rd_data, rd_resp, rd_s);
        check_eq("post_rst_reg5", 64'(rd_data), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
